// File: rtl/gshare_branch_predictor_if.sv
// Lookup/update bundle between the ID/EX pipeline stages and the gshare branch predictor.
// The ID/EX side uses the master modport; the predictor uses the slave modport.
interface gshare_branch_predictor_if #(
  parameter int PC_W    = 32,
  parameter int INDEX_W = 8,
  parameter int GHR_W   = 8
);
  // ID-stage lookup request and its combinational prediction
  logic               lookup_valid;
  logic [PC_W-1:0]    lookup_pc;
  logic               pred_taken;
  logic [INDEX_W-1:0] pred_index;
  logic [GHR_W-1:0]   pred_ghr;
  logic               pred_hit;
  logic [PC_W-1:0]    pred_target;

  // EX-stage resolution carrying the lookup-time index and history
  logic               update_valid;
  logic [PC_W-1:0]    update_pc;
  logic [INDEX_W-1:0] update_index;
  logic [GHR_W-1:0]   update_ghr;
  logic               update_taken;
  logic               update_mispredict;
  logic [PC_W-1:0]    update_target;

  modport master (
    output lookup_valid, lookup_pc,
    output update_valid, update_pc, update_index, update_ghr,
    output update_taken, update_mispredict, update_target,
    input  pred_taken, pred_index, pred_ghr, pred_hit, pred_target
  );

  modport slave (
    input  lookup_valid, lookup_pc,
    input  update_valid, update_pc, update_index, update_ghr,
    input  update_taken, update_mispredict, update_target,
    output pred_taken, pred_index, pred_ghr, pred_hit, pred_target
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: speculative GHR, saturating-counter PHT with hardware init, history repair
// and statistics. Define GSHARE_BTB_EN to build the optional direct-mapped BTB.
module gshare_branch_predictor #(
  parameter int PC_W      = 32,
  parameter int INDEX_W   = 8,
  parameter int GHR_W     = 8,
  parameter int CTR_W     = 2,
  parameter int BTB_IDX_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    ready,
  gshare_branch_predictor_if.slave bus,
  output logic [31:0]             stat_branches,
  output logic [31:0]             stat_mispredicts
);

  localparam int DEPTH   = 1 << INDEX_W;
  localparam int WEAK_NT = (1 << (CTR_W - 1)) - 1;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [INDEX_W-1:0] init_ptr;
  logic [GHR_W-1:0]   ghr;
  logic [GHR_W-1:0]   ghr_next;
  logic [GHR_W-1:0]   ghr_shifted;
  logic [GHR_W-1:0]   ghr_repaired;
  logic [CTR_W-1:0]   pht [DEPTH];

  logic               run;
  logic               do_lookup;
  logic               do_update;
  logic               do_repair;
  logic [INDEX_W-1:0] lookup_idx;
  logic [CTR_W-1:0]   lookup_ctr;
  logic               pred_dir;
  logic [CTR_W-1:0]   update_ctr;
  logic [CTR_W-1:0]   update_ctr_next;

  assign run       = (state == S_RUN);
  assign ready     = run;
  assign do_lookup = run & bus.lookup_valid;
  assign do_update = run & bus.update_valid;
  assign do_repair = do_update & bus.update_mispredict;

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == S_INIT) init_ptr <= init_ptr + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      S_INIT: if (init_ptr == '1) state_next = S_RUN;
      S_RUN:  state_next = S_RUN;
    endcase
  end

  // ---------------------------------------------------------------- lookup
  assign lookup_idx     = bus.lookup_pc[INDEX_W+1:2] ^ INDEX_W'(ghr);
  assign lookup_ctr     = pht[lookup_idx];
  assign pred_dir       = run & lookup_ctr[CTR_W-1];
  assign bus.pred_taken = pred_dir;
  assign bus.pred_index = lookup_idx;
  assign bus.pred_ghr   = ghr;

  // ---------------------------------------------------------------- global history
  if (GHR_W == 1) begin : g_ghr_single
    assign ghr_shifted  = pred_dir;
    assign ghr_repaired = bus.update_taken;
  end else begin : g_ghr_multi
    assign ghr_shifted  = {ghr[GHR_W-2:0], pred_dir};
    assign ghr_repaired = {bus.update_ghr[GHR_W-2:0], bus.update_taken};
  end

  // A repair restarts history from the mispredicted branch, discarding any same-cycle shift.
  always_comb begin
    ghr_next = ghr;
    if (do_repair)      ghr_next = ghr_repaired;
    else if (do_lookup) ghr_next = ghr_shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) ghr <= '0;
    else     ghr <= ghr_next;
  end

  // ---------------------------------------------------------------- pattern history table
  assign update_ctr = pht[bus.update_index];

  always_comb begin
    update_ctr_next = update_ctr;
    if (bus.update_taken) begin
      if (update_ctr != '1) update_ctr_next = update_ctr + 1'b1;
    end else begin
      if (update_ctr != '0) update_ctr_next = update_ctr - 1'b1;
    end
  end

  // NOTE: the PHT array has no reset; the INIT sweep writes every entry before any lookup is honoured.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_INIT)  pht[init_ptr]         <= CTR_W'(WEAK_NT);
      else if (do_update)   pht[bus.update_index] <= update_ctr_next;
    end
  end

  // ---------------------------------------------------------------- statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_update && stat_branches != '1)    stat_branches    <= stat_branches + 32'd1;
      if (do_repair && stat_mispredicts != '1) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

  // ---------------------------------------------------------------- branch target buffer
`ifdef GSHARE_BTB_EN
  localparam int BTB_DEPTH = 1 << BTB_IDX_W;
  localparam int TAG_W     = PC_W - BTB_IDX_W - 2;

  logic [BTB_DEPTH-1:0] btb_valid;
  logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
  logic [PC_W-1:0]      btb_target [BTB_DEPTH];
  logic [BTB_IDX_W-1:0] btb_rd_idx;
  logic [BTB_IDX_W-1:0] btb_wr_idx;
  logic                 btb_hit;
  logic                 btb_write;

  assign btb_rd_idx = bus.lookup_pc[BTB_IDX_W+1:2];
  assign btb_wr_idx = bus.update_pc[BTB_IDX_W+1:2];
  assign btb_write  = do_update & bus.update_taken;
  assign btb_hit    = run & btb_valid[btb_rd_idx] &
                      (btb_tag[btb_rd_idx] == bus.lookup_pc[PC_W-1:BTB_IDX_W+2]);

  assign bus.pred_hit    = btb_hit;
  assign bus.pred_target = btb_hit ? btb_target[btb_rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst)            btb_valid             <= '0;
    else if (btb_write) btb_valid[btb_wr_idx] <= 1'b1;
  end

  // Tag and target are qualified by the valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && btb_write) begin
      btb_tag[btb_wr_idx]    <= bus.update_pc[PC_W-1:BTB_IDX_W+2];
      btb_target[btb_wr_idx] <= bus.update_target;
    end
  end
`else
  logic [BTB_IDX_W-1:0] unused_btb_idx;

  assign bus.pred_hit    = 1'b0;
  assign bus.pred_target = '0;
  assign unused_btb_idx  = '0;
`endif

  // Address bits outside the index/tag fields and the oldest carried history bit are not needed.
  logic unused_bits;
  assign unused_bits = ^{bus.lookup_pc, bus.update_pc, bus.update_target, bus.update_ghr};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Self-checking bench for gshare_branch_predictor: directed scenarios plus randomized traffic
// compared against a behavioural model of the predictor kept in plain integer arrays.
module tb_gshare_branch_predictor;

  localparam int PC_W      = 32;
  localparam int INDEX_W   = 8;
  localparam int GHR_W     = 8;
  localparam int CTR_W     = 2;
  localparam int BTB_IDX_W = 4;
  localparam int DEPTH     = 1 << INDEX_W;
  localparam int CTR_MAX   = (1 << CTR_W) - 1;
  localparam int WEAK_NT   = (1 << (CTR_W - 1)) - 1;
  localparam int GHR_MASK  = (1 << GHR_W) - 1;
  localparam int BTB_N     = 1 << BTB_IDX_W;
  localparam longint STAT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  gshare_branch_predictor_if #(.PC_W(PC_W), .INDEX_W(INDEX_W), .GHR_W(GHR_W)) bus ();

  gshare_branch_predictor #(
    .PC_W(PC_W), .INDEX_W(INDEX_W), .GHR_W(GHR_W), .CTR_W(CTR_W), .BTB_IDX_W(BTB_IDX_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ready           (ready),
    .bus             (bus),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model state
  int          pht_m [DEPTH];
  int          ghr_m       = 0;
  int          init_left   = DEPTH;
  bit          ready_m     = 1'b0;
  longint      br_m        = 0;
  longint      mp_m        = 0;
  bit          btb_v_m   [BTB_N];
  int unsigned btb_tag_m [BTB_N];
  int unsigned btb_tgt_m [BTB_N];

  function automatic int idx_m(input int unsigned pc);
    return int'(((pc >> 2) ^ int'(ghr_m)) % DEPTH);
  endfunction

  function automatic bit pred_m(input int unsigned pc);
    return ready_m && (pht_m[idx_m(pc)] > WEAK_NT);
  endfunction

  function automatic bit hit_m(input int unsigned pc);
`ifdef GSHARE_BTB_EN
    int unsigned b;
    b = (pc >> 2) % BTB_N;
    return ready_m && btb_v_m[b] && (btb_tag_m[b] == (pc >> (BTB_IDX_W + 2)));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned target_m(input int unsigned pc);
    if (!hit_m(pc)) return 0;
    return btb_tgt_m[(pc >> 2) % BTB_N];
  endfunction

  task automatic drive_idle();
    bus.lookup_valid      = 1'b0;
    bus.lookup_pc         = '0;
    bus.update_valid      = 1'b0;
    bus.update_pc         = '0;
    bus.update_index      = '0;
    bus.update_ghr        = '0;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b0;
    bus.update_target     = '0;
  endtask

  task automatic drive_random();
    bus.lookup_valid      = 1'($urandom);
    bus.lookup_pc         = $urandom;
    bus.update_valid      = 1'($urandom);
    bus.update_pc         = $urandom;
    bus.update_index      = INDEX_W'($urandom);
    bus.update_ghr        = GHR_W'($urandom);
    bus.update_taken      = 1'($urandom);
    bus.update_mispredict = 1'($urandom);
    bus.update_target     = $urandom;
  endtask

  // Apply the effect of the currently driven inputs to the model, then advance one clock.
  task automatic tick();
    bit lp;
    int i;
    int unsigned b;
    if (rst) begin
      ghr_m = 0; init_left = DEPTH; ready_m = 1'b0; br_m = 0; mp_m = 0;
      for (int k = 0; k < BTB_N; k++) btb_v_m[k] = 1'b0;
    end else if (!ready_m) begin
      init_left--;
      if (init_left == 0) begin
        ready_m = 1'b1;
        for (int k = 0; k < DEPTH; k++) pht_m[k] = WEAK_NT;
      end
    end else begin
      lp = pred_m(bus.lookup_pc);
      if (bus.update_valid) begin
        i = int'(bus.update_index);
        if (bus.update_taken && pht_m[i] < CTR_MAX) pht_m[i]++;
        if (!bus.update_taken && pht_m[i] > 0)      pht_m[i]--;
        if (br_m < STAT_MAX) br_m++;
`ifdef GSHARE_BTB_EN
        if (bus.update_taken) begin
          b = (bus.update_pc >> 2) % BTB_N;
          btb_v_m[b]   = 1'b1;
          btb_tag_m[b] = bus.update_pc >> (BTB_IDX_W + 2);
          btb_tgt_m[b] = bus.update_target;
        end
`endif
      end
      if (bus.update_valid && bus.update_mispredict) begin
        if (mp_m < STAT_MAX) mp_m++;
        ghr_m = ((int'(bus.update_ghr) << 1) | int'(bus.update_taken)) & GHR_MASK;
      end else if (bus.lookup_valid) begin
        ghr_m = ((ghr_m << 1) | int'(lp)) & GHR_MASK;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      drive_random();
      #1;
      vectors++;
      if (ready !== 1'b0 || bus.pred_taken !== 1'b0 || bus.pred_hit !== 1'b0) begin
        miscompares++;
        $display("FAIL init_outputs cycle %0d: ready=%b pred_taken=%b pred_hit=%b, expected 0 0 0",
                 c, ready, bus.pred_taken, bus.pred_hit);
      end
      tick();
    end
    drive_idle();
    bus.lookup_pc = $urandom;
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_rise: ready=%b after %0d init cycles, expected 1", ready, DEPTH);
    end
    vectors++;
    if (bus.pred_taken !== 1'b0 || bus.pred_ghr !== 8'h00 || bus.pred_target !== 32'h0) begin
      miscompares++;
      $display("FAIL post_init_lookup: pred_taken=%b pred_ghr=%h pred_target=%h, expected 0 00 0",
               bus.pred_taken, bus.pred_ghr, bus.pred_target);
    end
    vectors++;
    if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
      miscompares++;
      $display("FAIL init_stats: branches=%0d mispredicts=%0d, expected 0 0",
               stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_counter_saturation();
    bit seq_taken [9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    bit exp_pred  [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int k = 0; k < 9; k++) begin
      drive_idle();
      bus.update_valid = 1'b1;
      bus.update_index = 8'h12;
      bus.update_taken = seq_taken[k];
      tick();
      drive_idle();
      bus.lookup_pc = 32'h48;
      #1;
      vectors++;
      if (bus.pred_taken !== exp_pred[k] || bus.pred_index !== 8'h12) begin
        miscompares++;
        $display("FAIL counter_sat step %0d: pred_taken=%b pred_index=%h, expected %b 12",
                 k, bus.pred_taken, bus.pred_index, exp_pred[k]);
      end
    end
    vectors++;
    if (stat_branches !== 32'd9) begin
      miscompares++;
      $display("FAIL counter_sat_stats: branches=%0d, expected 9", stat_branches);
    end
  endtask

  task automatic test_ghr_shift();
    logic [7:0] train   [3] = '{8'h10, 8'h11, 8'h13};
    logic [7:0] exp_ghr [3] = '{8'h00, 8'h01, 8'h03};
    for (int k = 0; k < 6; k++) begin
      drive_idle();
      bus.update_valid = 1'b1;
      bus.update_index = train[k / 2];
      bus.update_taken = 1'b1;
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      drive_idle();
      bus.lookup_valid = 1'b1;
      bus.lookup_pc    = 32'h40;
      #1;
      vectors++;
      if (bus.pred_ghr !== exp_ghr[k] || bus.pred_index !== (8'h10 ^ exp_ghr[k]) ||
          bus.pred_taken !== 1'b1) begin
        miscompares++;
        $display("FAIL ghr_shift lookup %0d: ghr=%h index=%h taken=%b, expected %h %h 1",
                 k, bus.pred_ghr, bus.pred_index, bus.pred_taken, exp_ghr[k], 8'h10 ^ exp_ghr[k]);
      end
      tick();
    end
    drive_idle();
    #1;
    vectors++;
    if (bus.pred_ghr !== 8'h07) begin
      miscompares++;
      $display("FAIL ghr_after_three: ghr=%h, expected 07", bus.pred_ghr);
    end
  endtask

  task automatic test_repair();
    longint br0;
    longint mp0;
    br0 = br_m;
    mp0 = mp_m;
    drive_idle();
    bus.lookup_valid      = 1'b1;
    bus.lookup_pc         = 32'h40;
    bus.update_valid      = 1'b1;
    bus.update_index      = 8'h30;
    bus.update_ghr        = 8'h05;
    bus.update_taken      = 1'b0;
    bus.update_mispredict = 1'b1;
    tick();
    drive_idle();
    #1;
    vectors++;
    if (bus.pred_ghr !== 8'h0A) begin
      miscompares++;
      $display("FAIL repair_ghr: ghr=%h, expected 0a", bus.pred_ghr);
    end
    vectors++;
    if (stat_branches !== 32'(br0 + 1) || stat_mispredicts !== 32'(mp0 + 1)) begin
      miscompares++;
      $display("FAIL repair_stats: branches=%0d mispredicts=%0d, expected %0d %0d",
               stat_branches, stat_mispredicts, br0 + 1, mp0 + 1);
    end
    // A mispredict flag without update_valid must be ignored.
    bus.update_mispredict = 1'b1;
    bus.update_ghr        = 8'h33;
    bus.update_taken      = 1'b1;
    tick();
    drive_idle();
    #1;
    vectors++;
    if (bus.pred_ghr !== 8'h0A || stat_branches !== 32'(br0 + 1) ||
        stat_mispredicts !== 32'(mp0 + 1)) begin
      miscompares++;
      $display("FAIL stray_mispredict: ghr=%h branches=%0d mispredicts=%0d, expected 0a %0d %0d",
               bus.pred_ghr, stat_branches, stat_mispredicts, br0 + 1, mp0 + 1);
    end
  endtask

  task automatic test_no_bypass();
    // GHR is 0x0A, so this PC indexes entry 0x20 which still holds weakly-not-taken.
    drive_idle();
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'((8'h20 ^ 8'h0A) << 2);
    bus.update_valid = 1'b1;
    bus.update_index = 8'h20;
    bus.update_taken = 1'b1;
    #1;
    vectors++;
    if (bus.pred_taken !== 1'b0 || bus.pred_index !== 8'h20) begin
      miscompares++;
      $display("FAIL no_bypass: pred_taken=%b index=%h, expected 0 20", bus.pred_taken, bus.pred_index);
    end
    tick();
    drive_idle();
    bus.lookup_pc = 32'((8'h20 ^ 8'h14) << 2);
    #1;
    vectors++;
    if (bus.pred_ghr !== 8'h14 || bus.pred_taken !== 1'b1) begin
      miscompares++;
      $display("FAIL after_same_index: ghr=%h pred_taken=%b, expected 14 1",
               bus.pred_ghr, bus.pred_taken);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      drive_random();
      bus.update_mispredict = ($urandom_range(0, 3) == 0);
      // A narrow PC pool makes BTB hits and index aliasing likely.
      bus.lookup_pc     = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      bus.update_pc     = 32'h1000 | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      #1;
      vectors++;
      if (ready !== ready_m || bus.pred_taken !== pred_m(bus.lookup_pc) ||
          bus.pred_index !== INDEX_W'(idx_m(bus.lookup_pc)) || bus.pred_ghr !== GHR_W'(ghr_m) ||
          bus.pred_hit !== hit_m(bus.lookup_pc) || bus.pred_target !== target_m(bus.lookup_pc) ||
          stat_branches !== 32'(br_m) || stat_mispredicts !== 32'(mp_m)) begin
        miscompares++;
        $display("FAIL random cycle %0d pc=%h: got rdy=%b tk=%b idx=%h ghr=%h hit=%b tgt=%h br=%0d mp=%0d; expected rdy=%b tk=%b idx=%h ghr=%h hit=%b tgt=%h br=%0d mp=%0d",
                 c, bus.lookup_pc, ready, bus.pred_taken, bus.pred_index, bus.pred_ghr,
                 bus.pred_hit, bus.pred_target, stat_branches, stat_mispredicts,
                 ready_m, pred_m(bus.lookup_pc), idx_m(bus.lookup_pc), ghr_m,
                 hit_m(bus.lookup_pc), target_m(bus.lookup_pc), br_m, mp_m);
      end
      tick();
    end
  endtask

  task automatic test_mid_reset();
    drive_random();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      drive_random();
      #1;
      vectors++;
      if (ready !== 1'b0 || stat_branches !== 32'd0 || stat_mispredicts !== 32'd0 ||
          bus.pred_ghr !== 8'h00) begin
        miscompares++;
        $display("FAIL mid_reset_init cycle %0d: ready=%b br=%0d mp=%0d ghr=%h, expected 0 0 0 00",
                 c, ready, stat_branches, stat_mispredicts, bus.pred_ghr);
      end
      tick();
    end
    drive_idle();
    #1;
    vectors++;
    if (ready !== 1'b1 || stat_branches !== 32'd0 || bus.pred_ghr !== 8'h00) begin
      miscompares++;
      $display("FAIL mid_reset_ready: ready=%b br=%0d ghr=%h, expected 1 0 00",
               ready, stat_branches, bus.pred_ghr);
    end
    for (int e = 0; e < DEPTH; e++) begin
      bus.lookup_pc = 32'(e << 2);
      #1;
      vectors++;
      if (bus.pred_taken !== 1'b0 || bus.pred_hit !== 1'b0) begin
        miscompares++;
        $display("FAIL reinit_entry %0d: pred_taken=%b pred_hit=%b, expected 0 0",
                 e, bus.pred_taken, bus.pred_hit);
      end
    end
  endtask

`ifdef GSHARE_BTB_EN
  task automatic test_btb();
    drive_idle();
    bus.update_valid  = 1'b1;
    bus.update_pc     = 32'h1000;
    bus.update_target = 32'h2000;
    bus.update_taken  = 1'b1;
    bus.update_index  = INDEX_W'($urandom);
    tick();
    bus.update_pc     = 32'h1044;
    bus.update_target = 32'h3000;
    bus.update_taken  = 1'b0;
    tick();
    drive_idle();
    bus.lookup_pc = 32'h1000;
    #1;
    vectors++;
    if (bus.pred_hit !== 1'b1 || bus.pred_target !== 32'h2000) begin
      miscompares++;
      $display("FAIL btb_hit: hit=%b target=%h, expected 1 00002000", bus.pred_hit, bus.pred_target);
    end
    bus.lookup_pc = 32'h1040;
    #1;
    vectors++;
    if (bus.pred_hit !== 1'b0 || bus.pred_target !== 32'h0) begin
      miscompares++;
      $display("FAIL btb_tag_miss: hit=%b target=%h, expected 0 0", bus.pred_hit, bus.pred_target);
    end
    bus.lookup_pc = 32'h1044;
    #1;
    vectors++;
    if (bus.pred_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL btb_not_taken_write: hit=%b, expected 0", bus.pred_hit);
    end
  endtask
`endif

  initial begin
    drive_idle();
    test_reset();
    test_counter_saturation();
    test_ghr_shift();
    test_repair();
    test_no_bypass();
    test_random();
    test_mid_reset();
`ifdef GSHARE_BTB_EN
    test_btb();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
